// File: rtl/arbitre_memoire.sv
// arbitre_memoire: shares the single-port MEMOIRE block between the CPU
// and the debug/loader port, with CPU priority and starvation relief.
module arbitre_memoire #(
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 8,
    parameter int ROM_LAST   = 20
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CPU_REQ,
    input  logic        CPU_WE,
    input  logic [15:0] CPU_ADRESSE,
    input  logic [7:0]  CPU_DATA_IN,
    output logic [7:0]  CPU_DATA_OUT,
    output logic        CPU_ACK,
    output logic        CPU_WP_ERR,
    input  logic        DBG_REQ,
    input  logic        DBG_WE,
    input  logic [15:0] DBG_ADRESSE,
    input  logic [7:0]  DBG_DATA_IN,
    output logic [7:0]  DBG_DATA_OUT,
    output logic        DBG_ACK,
    output logic        MEM_READ_ENABLE,
    output logic        MEM_WRITE_ENABLE,
    output logic [15:0] MEM_ADRESSE,
    output logic [7:0]  MEM_DATA_OUT,
    input  logic [7:0]  MEM_DATA_IN,
    output logic [1:0]  GRANT
);

    localparam int              SW         = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0]   STARVE_TOP = SW'(STARVE_MAX);
    localparam logic [7:0]      WAIT_LOAD  = 8'(MEM_LAT - 2);
    localparam logic [15:0]     ROM_TOP    = 16'(ROM_LAST);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [SW-1:0] starve;
    logic [7:0]    wait_cnt;
    logic          cmd_we;
    logic          cmd_dbg;
    logic          cmd_blk;

    logic          cpu_win;
    logic          dbg_win;
    logic          sel_we;
    logic          sel_blk;
    logic [15:0]   sel_adr;
    logic [7:0]    sel_dat;

    // Pick the winner among pending requests and mux its command.
    always_comb begin
        cpu_win = CPU_REQ && !(DBG_REQ && (starve >= STARVE_TOP));
        dbg_win = DBG_REQ && !cpu_win;
        sel_we  = cpu_win ? CPU_WE      : DBG_WE;
        sel_adr = cpu_win ? CPU_ADRESSE : DBG_ADRESSE;
        sel_dat = cpu_win ? CPU_DATA_IN : DBG_DATA_IN;
        sel_blk = cpu_win && CPU_WE && (CPU_ADRESSE <= ROM_TOP);
    end

    // Sequencer state register.
    always_ff @(posedge CLK) begin
        if (RST) state <= S_IDLE;
        else     state <= state_nx;
    end

    // Sequencer next state: one issue cycle, MEM_LAT-1 waits, one ack.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (cpu_win || dbg_win) state_nx = S_ISSUE;
            S_ISSUE: state_nx = S_WAIT;
            S_WAIT:  if (wait_cnt == 8'd0) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Starvation counter: DBG losing while pending climbs toward priority.
    always_ff @(posedge CLK) begin
        if (RST) begin
            starve <= '0;
        end else if (state == S_IDLE) begin
            if (dbg_win)
                starve <= '0;
            else if (cpu_win && DBG_REQ && starve < STARVE_TOP)
                starve <= starve + SW'(1);
        end
    end

    // Latency down-counter covering the WAIT cycles.
    always_ff @(posedge CLK) begin
        if (RST)
            wait_cnt <= '0;
        else if (state == S_ISSUE)
            wait_cnt <= WAIT_LOAD;
        else if (state == S_WAIT && wait_cnt != 8'd0)
            wait_cnt <= wait_cnt - 8'd1;
    end

    // Registered command, memory drive, acks and read data capture.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cmd_we           <= 1'b0;
            cmd_dbg          <= 1'b0;
            cmd_blk          <= 1'b0;
            GRANT            <= 2'b00;
            MEM_ADRESSE      <= '0;
            MEM_DATA_OUT     <= '0;
            MEM_READ_ENABLE  <= 1'b0;
            MEM_WRITE_ENABLE <= 1'b0;
            CPU_ACK          <= 1'b0;
            DBG_ACK          <= 1'b0;
            CPU_WP_ERR       <= 1'b0;
            CPU_DATA_OUT     <= '0;
            DBG_DATA_OUT     <= '0;
        end else begin
            MEM_READ_ENABLE  <= 1'b0;
            MEM_WRITE_ENABLE <= 1'b0;
            CPU_ACK          <= 1'b0;
            DBG_ACK          <= 1'b0;
            CPU_WP_ERR       <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cpu_win || dbg_win) begin
                        cmd_we           <= sel_we;
                        cmd_dbg          <= dbg_win;
                        cmd_blk          <= sel_blk;
                        GRANT            <= dbg_win ? 2'b10 : 2'b01;
                        MEM_ADRESSE      <= sel_adr;
                        MEM_DATA_OUT     <= sel_dat;
                        MEM_READ_ENABLE  <= !sel_we;
                        MEM_WRITE_ENABLE <= sel_we && !sel_blk;
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == 8'd0) begin
                        CPU_ACK    <= !cmd_dbg;
                        DBG_ACK    <= cmd_dbg;
                        CPU_WP_ERR <= cmd_blk;
                        if (!cmd_we) begin
                            if (cmd_dbg) DBG_DATA_OUT <= MEM_DATA_IN;
                            else         CPU_DATA_OUT <= MEM_DATA_IN;
                        end
                    end
                end
                S_DONE: begin
                    GRANT        <= 2'b00;
                    MEM_ADRESSE  <= '0;
                    MEM_DATA_OUT <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_arbitre_memoire.sv
// tb_arbitre_memoire: directed stimulus, per-cycle check against a
// transaction-level model, plus literal checks and a MEM_LAT=3 instance.
module tb_arbitre_memoire;

    localparam int L     = 2;
    localparam int SMAX  = 8;
    localparam int ROMLS = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [15:0] cpu_adr = '0;
    logic [7:0]  cpu_din = '0;
    logic        dbg_req = 1'b0;
    logic        dbg_we = 1'b0;
    logic [15:0] dbg_adr = '0;
    logic [7:0]  dbg_din = '0;

    logic [7:0]  cpu_dout;
    logic [7:0]  dbg_dout;
    logic        cpu_ack;
    logic        dbg_ack;
    logic        wp_err;
    logic        re;
    logic        wr;
    logic [15:0] madr;
    logic [7:0]  mdo;
    logic [7:0]  mdi;
    logic [1:0]  grant;

    logic        c3_req = 1'b0;
    logic [15:0] c3_adr = '0;
    logic [7:0]  c3_dout;
    logic        c3_ack;
    logic        c3_wp;
    logic [7:0]  d3_dout;
    logic        d3_ack;
    logic        re3;
    logic        wr3;
    logic [15:0] madr3;
    logic [7:0]  mdo3;
    logic [7:0]  mdi3;
    logic [1:0]  grant3;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    arbitre_memoire #(.MEM_LAT(L), .STARVE_MAX(SMAX), .ROM_LAST(ROMLS)) dut (
        .CLK(clk), .RST(rst),
        .CPU_REQ(cpu_req), .CPU_WE(cpu_we),
        .CPU_ADRESSE(cpu_adr), .CPU_DATA_IN(cpu_din),
        .CPU_DATA_OUT(cpu_dout), .CPU_ACK(cpu_ack), .CPU_WP_ERR(wp_err),
        .DBG_REQ(dbg_req), .DBG_WE(dbg_we),
        .DBG_ADRESSE(dbg_adr), .DBG_DATA_IN(dbg_din),
        .DBG_DATA_OUT(dbg_dout), .DBG_ACK(dbg_ack),
        .MEM_READ_ENABLE(re), .MEM_WRITE_ENABLE(wr),
        .MEM_ADRESSE(madr), .MEM_DATA_OUT(mdo),
        .MEM_DATA_IN(mdi), .GRANT(grant)
    );

    arbitre_memoire #(.MEM_LAT(3), .STARVE_MAX(SMAX), .ROM_LAST(ROMLS)) dut3 (
        .CLK(clk), .RST(rst),
        .CPU_REQ(c3_req), .CPU_WE(1'b0),
        .CPU_ADRESSE(c3_adr), .CPU_DATA_IN(8'h00),
        .CPU_DATA_OUT(c3_dout), .CPU_ACK(c3_ack), .CPU_WP_ERR(c3_wp),
        .DBG_REQ(1'b0), .DBG_WE(1'b0),
        .DBG_ADRESSE(16'h0000), .DBG_DATA_IN(8'h00),
        .DBG_DATA_OUT(d3_dout), .DBG_ACK(d3_ack),
        .MEM_READ_ENABLE(re3), .MEM_WRITE_ENABLE(wr3),
        .MEM_ADRESSE(madr3), .MEM_DATA_OUT(mdo3),
        .MEM_DATA_IN(mdi3), .GRANT(grant3)
    );

    // Memory stand-in: data is only correct in the cycle before capture.
    logic [7:0] phys [0:255];
    logic [3:0] age = '0;
    logic [3:0] age3 = '0;

    always @(posedge clk) begin
        if (re) age <= 4'd1;
        else if (age != 4'd0 && age != 4'd15) age <= age + 4'd1;
        if (re3) age3 <= 4'd1;
        else if (age3 != 4'd0 && age3 != 4'd15) age3 <= age3 + 4'd1;
        if (wr) phys[madr[7:0]] = mdo;
    end

    assign mdi  = (age == 4'(L - 1)) ? phys[madr[7:0]] : ~phys[madr[7:0]];
    assign mdi3 = (age3 == 4'd2) ? phys[madr3[7:0]] : ~phys[madr3[7:0]];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Transaction-level model: one record in flight, outputs by phase.
    logic [7:0]  refmem [0:255];
    int          cyc = 0;
    bit          m_ok = 1'b0;
    bit          busy = 1'b0;
    int          t0 = 0;
    int          starve = 0;
    int          p;
    bit          o_dbg;
    bit          o_we;
    bit          o_blk;
    logic [15:0] o_adr;
    logic [7:0]  o_dat;
    logic        e_re, e_wr, e_cack, e_dack, e_wp;
    logic [1:0]  e_grant;
    logic [15:0] e_adr;
    logic [7:0]  e_mdo;
    logic [7:0]  e_cdo = '0;
    logic [7:0]  e_ddo = '0;

    always @(posedge clk) begin
        if (rst) begin
            busy  = 1'b0;
            starve = 0;
            e_cdo = '0;
            e_ddo = '0;
        end else if (busy) begin
            if (cyc == t0 + L + 1) busy = 1'b0;
        end else if (cpu_req || dbg_req) begin
            o_dbg = dbg_req && (!cpu_req || starve >= SMAX);
            if (o_dbg) starve = 0;
            else if (dbg_req && starve < SMAX) starve++;
            o_we  = o_dbg ? dbg_we : cpu_we;
            o_adr = o_dbg ? dbg_adr : cpu_adr;
            o_dat = o_dbg ? dbg_din : cpu_din;
            o_blk = !o_dbg && o_we && (o_adr <= ROMLS);
            busy  = 1'b1;
            t0    = cyc;
        end
        e_re = 0; e_wr = 0; e_cack = 0; e_dack = 0; e_wp = 0;
        e_grant = 2'b00; e_adr = '0; e_mdo = '0;
        if (busy) begin
            p = cyc + 1 - t0;
            e_grant = o_dbg ? 2'b10 : 2'b01;
            e_adr = o_adr;
            e_mdo = o_dat;
            if (p == 1) begin
                e_re = !o_we;
                e_wr = o_we && !o_blk;
                if (e_wr) refmem[o_adr[7:0]] = o_dat;
            end
            if (p == L + 1) begin
                e_dack = o_dbg;
                e_cack = !o_dbg;
                e_wp = o_blk;
                if (!o_we) begin
                    if (o_dbg) e_ddo = refmem[o_adr[7:0]];
                    else       e_cdo = refmem[o_adr[7:0]];
                end
            end
        end
        cyc++;
        m_ok = 1'b1;
    end

    // Compare every output against the model mid-cycle.
    always @(negedge clk) begin
        if (m_ok) begin
            chk("m_grant", 32'(grant), 32'(e_grant));
            chk("m_re", 32'(re), 32'(e_re));
            chk("m_wr", 32'(wr), 32'(e_wr));
            chk("m_adr", 32'(madr), 32'(e_adr));
            chk("m_mdo", 32'(mdo), 32'(e_mdo));
            chk("m_cack", 32'(cpu_ack), 32'(e_cack));
            chk("m_dack", 32'(dbg_ack), 32'(e_dack));
            chk("m_wp", 32'(wp_err), 32'(e_wp));
            chk("m_cdo", 32'(cpu_dout), 32'(e_cdo));
            chk("m_ddo", 32'(dbg_dout), 32'(e_ddo));
        end
    end

    task automatic xfer(input bit dbg, input bit we, input logic [15:0] a,
                        input logic [7:0] d, output int n);
        @(negedge clk);
        if (dbg) begin
            dbg_req = 1; dbg_we = we; dbg_adr = a; dbg_din = d;
        end else begin
            cpu_req = 1; cpu_we = we; cpu_adr = a; cpu_din = d;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(dbg ? dbg_ack : cpu_ack) && n < 20);
        cpu_req = 0;
        dbg_req = 0;
    endtask

    initial begin
        int n;
        int k;
        int acks;
        int dpos [2];
        int nd;
        for (int i = 0; i < 256; i++) begin
            phys[i]   = 8'(i * 7 + 1);
            refmem[i] = 8'(i * 7 + 1);
        end
        phys[3]   = 8'hE9;
        refmem[3] = 8'hE9;

        repeat (3) @(negedge clk);
        chk("rst_grant", 32'(grant), 0);
        chk("rst_re", 32'(re), 0);
        chk("rst_cdo", 32'(cpu_dout), 0);
        rst = 0;

        // CPU read of address 3, cycle by cycle
        @(negedge clk);
        cpu_req = 1; cpu_we = 0; cpu_adr = 16'h0003; cpu_din = 8'h11;
        @(negedge clk);
        chk("rd_re_t1", 32'(re), 1);
        chk("rd_adr_t1", 32'(madr), 3);
        chk("rd_grant_t1", 32'(grant), 1);
        @(negedge clk);
        chk("rd_re_t2", 32'(re), 0);
        chk("rd_adr_t2", 32'(madr), 3);
        @(negedge clk);
        chk("rd_ack_t3", 32'(cpu_ack), 1);
        chk("rd_data_t3", 32'(cpu_dout), 32'hE9);
        chk("rd_grant_t3", 32'(grant), 1);
        cpu_req = 0;
        @(negedge clk);
        chk("rd_ack_t4", 32'(cpu_ack), 0);
        chk("rd_grant_t4", 32'(grant), 0);
        chk("rd_adr_t4", 32'(madr), 0);

        // DBG write then read back
        xfer(1, 1, 16'h0015, 8'h5A, n);
        chk("dbg_wr_lat", n, 3);
        chk("dbg_wr_dout", 32'(dbg_dout), 0);
        chk("dbg_wr_mem", 32'(phys[21]), 32'h5A);
        xfer(1, 0, 16'h0015, 8'h00, n);
        chk("dbg_rd_data", 32'(dbg_dout), 32'h5A);

        // write protection and its boundary
        xfer(0, 1, 16'h0002, 8'h77, n);
        chk("wp_lat", n, 3);
        chk("wp_err", 32'(wp_err), 1);
        chk("wp_mem", 32'(phys[2]), 32'h0F);
        chk("wp_dout", 32'(cpu_dout), 32'hE9);
        xfer(1, 1, 16'h0002, 8'h77, n);
        chk("dbg_wp_mem", 32'(phys[2]), 32'h77);
        xfer(0, 1, 16'd20, 8'h33, n);
        chk("wp20_err", 32'(wp_err), 1);
        chk("wp20_mem", 32'(phys[20]), 32'h8D);
        xfer(0, 1, 16'd21, 8'h44, n);
        chk("wp21_err", 32'(wp_err), 0);
        chk("wp21_mem", 32'(phys[21]), 32'h44);

        // both requests held: 8 CPU grants then one DBG grant, repeating
        @(negedge clk);
        cpu_req = 1; cpu_we = 0; cpu_adr = 16'd5; cpu_din = 0;
        dbg_req = 1; dbg_we = 0; dbg_adr = 16'd6; dbg_din = 0;
        acks = 0; nd = 0; k = 0; dpos[0] = 0; dpos[1] = 0;
        while (acks < 18 && k < 200) begin
            @(negedge clk);
            k++;
            if (cpu_ack || dbg_ack) begin
                acks++;
                if (dbg_ack && nd < 2) begin
                    dpos[nd] = acks;
                    nd++;
                end
            end
        end
        cpu_req = 0;
        dbg_req = 0;
        chk("starve_acks", acks, 18);
        chk("starve_dbg1", dpos[0], 9);
        chk("starve_dbg2", dpos[1], 18);
        chk("b2b_span", k, 71);

        // reset during WAIT of a CPU read
        @(negedge clk);
        cpu_req = 1; cpu_we = 0; cpu_adr = 16'h0003;
        @(negedge clk);
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        chk("rstmid_ack", 32'(cpu_ack), 0);
        chk("rstmid_grant", 32'(grant), 0);
        chk("rstmid_re", 32'(re), 0);
        chk("rstmid_adr", 32'(madr), 0);
        chk("rstmid_cdo", 32'(cpu_dout), 0);
        rst = 0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!cpu_ack && k < 20);
        cpu_req = 0;
        chk("rstmid_relat", k, 3);
        chk("rstmid_data", 32'(cpu_dout), 32'hE9);

        // MEM_LAT=3 instance: ack at t+4, period 5
        @(negedge clk);
        c3_req = 1; c3_adr = 16'h0003;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!c3_ack && k < 20);
        chk("l3_lat", k, 4);
        chk("l3_data", 32'(c3_dout), 32'hE9);
        c3_adr = 16'd21;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!c3_ack && k < 20);
        c3_req = 0;
        chk("l3_period", k, 5);
        chk("l3_data2", 32'(c3_dout), 32'h44);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/arbitre_memoire.md
# arbitre_memoire

Arbiter and sequencer sharing the single-port MEMOIRE ROM/RAM block between the 6502 CPU core and a debug/loader port. Each side uses a REQ/ACK handshake. The arbiter serialises accesses and drives the memory's read/write enables, address and write data for exactly one issue cycle. It then waits out the memory's latch-then-access latency and returns read data with a one-cycle ACK. CPU has priority; a starvation counter guarantees the debug port eventually wins. CPU writes into the ROM window are blocked.

## Interface
- MEM_LAT, 2: cycles from issue cycle to the cycle in which read data is captured plus one; ACK asserted MEM_LAT cycles after issue
- STARVE_MAX, 8: consecutive cycles DBG_REQ may be pending while losing before it takes priority
- ROM_LAST, 20: highest address of the ROM window; CPU writes at addresses <= ROM_LAST are suppressed

- CLK  in  1  system clock, all logic on rising edge
- RST  in  1  synchronous, active-high reset
- CPU_REQ  in  1  CPU access request, held until CPU_ACK
- CPU_WE  in  1  1 = write, 0 = read
- CPU_ADRESSE  in  16  CPU address
- CPU_DATA_IN  in  8  CPU write data
- CPU_DATA_OUT  out  8  read data, valid while CPU_ACK=1 and held until the next CPU read ACK
- CPU_ACK  out  1  one-cycle completion pulse
- CPU_WP_ERR  out  1  pulses with CPU_ACK when a CPU write was blocked
- DBG_REQ, DBG_WE, DBG_ADRESSE[15:0], DBG_DATA_IN[7:0]  in  same meaning for debug port
- DBG_DATA_OUT  out  8  same as the CPU equivalent
- DBG_ACK  out  1  same as the CPU equivalent
- MEM_READ_ENABLE  out  1  to memory READ_ENABLE
- MEM_WRITE_ENABLE  out  1  to memory WRITE_ENABLE
- MEM_ADRESSE  out  16  to memory ADRESSE_CPU
- MEM_DATA_OUT  out  8  to memory DATA_to_MEMORY_IN
- MEM_DATA_IN  in  8  from memory DATA_MICRO_OUT
- GRANT  out  2  00 none, 01 CPU, 10 DBG; owner of the transaction in flight

## Operation
- FSM states:
  - IDLE: arbitrate.
  - ISSUE: exactly 1 cycle.
  - WAIT: MEM_LAT-1 cycles, via a down-counter.
  - DONE: 1 cycle, ACK.
  - DONE always returns to IDLE.
- Arbitration in IDLE:
  - Only one REQ high: that requester wins.
  - Both high: CPU wins unless the starve counter is >= STARVE_MAX, in which case DBG wins.
- Starve counter:
  - Increments, saturating at STARVE_MAX, in every IDLE cycle where DBG_REQ=1 and CPU is granted.
  - Clears when DBG is granted, and on RST.
- On grant, the winner's WE, address and write data are registered, and GRANT is set.
  - Requester inputs are ignored after the grant until its ACK.
- ISSUE drives MEM_ADRESSE and MEM_DATA_OUT, and raises MEM_READ_ENABLE (read) or MEM_WRITE_ENABLE (write).
- Blocked write: a CPU write with address <= ROM_LAST raises no enable.
  - Sequencing is otherwise identical.
  - CPU_WP_ERR=1 in DONE.
- MEM_ADRESSE and MEM_DATA_OUT stay stable from ISSUE through DONE, covering the memory's latch and access edges. Both are 0 in IDLE.
- Read data capture: MEM_DATA_IN is captured at the rising edge ending the last WAIT cycle, then presented on the owner's DATA_OUT in DONE.
- A write's ACK carries no data; DATA_OUT keeps its previous value.
- A REQ still high in the IDLE cycle after DONE is treated as a new request.

## Timing
- Requests are sampled in IDLE cycle t:
  - ISSUE at t+1.
  - WAIT at t+2 .. t+MEM_LAT.
  - DONE/ACK at t+1+MEM_LAT, which is t+3 at default.
  - IDLE at t+2+MEM_LAT.
- Back-to-back throughput is one access per MEM_LAT+2 cycles (4 at default).
- Enables are high for exactly one cycle per transaction and never high outside ISSUE.
- ACK and WP_ERR are single-cycle pulses, registered.
- Reset values: every output 0; FSM IDLE; starve counter 0; internal command registers 0.
- RST mid-transaction: the transaction is aborted and no ACK is produced. Enables drop the cycle after RST. The requester must re-request.
- RST has priority over all other events.

## Test plan
- CPU read, address 3, memory returns 0xE9: MEM_READ_ENABLE=1 only at t+1, MEM_ADRESSE=0x0003 from t+1 to t+3, CPU_ACK=1 and CPU_DATA_OUT=0xE9 at t+3, GRANT=01 from t+1 to t+3.
- DBG write 0x5A to 0x0015, then DBG read of 0x0015: MEM_WRITE_ENABLE pulses once with MEM_DATA_OUT=0x5A held through DONE; the following read ACK returns 0x5A.
- CPU write 0x77 to 0x0002: MEM_WRITE_ENABLE never rises; CPU_ACK and CPU_WP_ERR both pulse at t+3; a DBG write to the same address is not blocked.
- CPU_REQ and DBG_REQ held continuously with STARVE_MAX=8: CPU is granted repeatedly; DBG is granted once the counter reaches 8; the counter clears; the pattern repeats; no ACK ever coincides with another.
- RST asserted during WAIT of a CPU read: no CPU_ACK; all outputs 0 the next cycle; CPU_REQ still high after RST release gives a full new transaction with ACK 3 cycles after the first IDLE.
- MEM_LAT=3: ACK at t+4, data captured at the end of the second WAIT cycle; period 5 cycles.
